fifo_ctrl: RTL and testbench

Single-clock sample FIFO on the 32 kHz always-on domain. Buffers sensor frame data between the sampling front end and the host read path. Produces one-cycle occupancy event pulses fifo_upov_flag, fifo_downov_flag and fifo_waterline_flag. int_ctrl consumes these pulses directly as interrupt sources.

---
 rtl/fifo_pkg.sv | 16 +
 rtl/fifo_mem_rf.sv | 33 +++
 rtl/fifo_ctrl.sv | 147 ++++++++++++++
 tb/tb_fifo_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared defaults and mode encodings for the always-on sample FIFO.
package fifo_pkg;

    localparam int unsigned FIFO_DW    = 16;
    localparam int unsigned FIFO_DEPTH = 32;

    // Behaviour of a push into a full FIFO with no simultaneous pop.
    typedef enum logic {
        OVW_DROP   = 1'b0,
        OVW_OLDEST = 1'b1
    } ovw_mode_e;

    // Waterline register value that disables the waterline event.
    localparam int unsigned WL_DISABLE = 0;

endpackage : fifo_pkg

// File: rtl/fifo_mem_rf.sv
// DEPTH x DW register file with one synchronous write port and one
// asynchronous read port. Storage is not reset.
//   clk          : write clock
//   we/waddr/wdata : write port
//   raddr/rdata  : combinational read port
module fifo_mem_rf
    import fifo_pkg::*;
#(
    parameter int unsigned DW    = FIFO_DW,
    parameter int unsigned DEPTH = FIFO_DEPTH,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port.
    assign rdata = mem[raddr];

endmodule : fifo_mem_rf

// File: rtl/fifo_ctrl.sv
// Single-clock sample FIFO on the 32 kHz always-on domain with registered
// status and one-cycle overflow / underflow / waterline event pulses.
//   clk_32k, rst_n           : clock, async active-low reset
//   wr_en, wr_data           : push request and data
//   rd_en, rd_data, rd_valid : pop request, registered popped word, valid pulse
//   fifo_flush               : synchronous clear, highest priority
//   rg_fifo_ovw_en           : 0 drop new word when full, 1 overwrite oldest
//   rg_fifo_waterline        : waterline level, 0 disables the event
//   fifo_cnt/full/empty      : registered occupancy status
//   fifo_*_flag              : registered event pulses
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned DW    = FIFO_DW,
    parameter int unsigned DEPTH = FIFO_DEPTH,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk_32k,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    input  logic          fifo_flush,
    input  logic          rg_fifo_ovw_en,
    input  logic [AW:0]   rg_fifo_waterline,
    output logic [AW:0]   fifo_cnt,
    output logic          fifo_full,
    output logic          fifo_empty,
    output logic          fifo_upov_flag,
    output logic          fifo_downov_flag,
    output logic          fifo_waterline_flag
);

    localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW:0]   WL_OFF  = (AW+1)'(WL_DISABLE);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [AW-1:0] wr_ptr, wr_ptr_d;
    logic [AW-1:0] rd_ptr, rd_ptr_d;
    logic [AW:0]   cnt_d;
    logic [DW-1:0] mem_rdata;
    logic          push, pop, ovw_hit;
    logic          upov_d, downov_d, wl_d;
    ovw_mode_e     ovw_mode;

    assign ovw_mode = ovw_mode_e'(rg_fifo_ovw_en);

    fifo_mem_rf #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk_32k),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (wr_data),
        .raddr (rd_ptr),
        .rdata (mem_rdata)
    );

    // Next-state: pointer/count updates and event detection.
    always_comb begin
        push     = 1'b0;
        pop      = 1'b0;
        ovw_hit  = 1'b0;
        upov_d   = 1'b0;
        downov_d = 1'b0;
        wl_d     = 1'b0;
        wr_ptr_d = wr_ptr;
        rd_ptr_d = rd_ptr;
        cnt_d    = fifo_cnt;

        if (fifo_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            pop      = rd_en && !fifo_empty;
            downov_d = rd_en && fifo_empty;

            // A pop in the same cycle frees the slot, so a full FIFO still accepts.
            if (wr_en) begin
                if (!fifo_full || pop) begin
                    push = 1'b1;
                end else begin
                    upov_d = 1'b1;
                    if (ovw_mode == OVW_OLDEST) begin
                        push    = 1'b1;
                        ovw_hit = 1'b1;
                    end
                end
            end

            if (push) begin
                wr_ptr_d = wr_ptr + PTR_ONE;
            end
            // Overwrite discards the oldest word by advancing the read side too.
            if (pop || ovw_hit) begin
                rd_ptr_d = rd_ptr + PTR_ONE;
            end

            if (push && !pop && !ovw_hit) begin
                cnt_d = fifo_cnt + CNT_ONE;
            end else if (pop && !push) begin
                cnt_d = fifo_cnt - CNT_ONE;
            end

            // Rising crossing only; levels above DEPTH are unreachable by cnt_d.
            wl_d = (rg_fifo_waterline != WL_OFF)
                && (fifo_cnt < rg_fifo_waterline)
                && (cnt_d >= rg_fifo_waterline);
        end
    end

    // State and output registers.
    always_ff @(posedge clk_32k or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr              <= '0;
            rd_ptr              <= '0;
            fifo_cnt            <= '0;
            fifo_full           <= 1'b0;
            fifo_empty          <= 1'b1;
            rd_data             <= '0;
            rd_valid            <= 1'b0;
            fifo_upov_flag      <= 1'b0;
            fifo_downov_flag    <= 1'b0;
            fifo_waterline_flag <= 1'b0;
        end else begin
            wr_ptr              <= wr_ptr_d;
            rd_ptr              <= rd_ptr_d;
            fifo_cnt            <= cnt_d;
            fifo_full           <= (cnt_d == CNT_MAX);
            fifo_empty          <= (cnt_d == '0);
            rd_valid            <= pop;
            fifo_upov_flag      <= upov_d;
            fifo_downov_flag    <= downov_d;
            fifo_waterline_flag <= wl_d;
            if (pop) begin
                rd_data <= mem_rdata;
            end
        end
    end

endmodule : fifo_ctrl

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_fifo_ctrl;

    localparam int DW    = 16;
    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic          clk_32k = 1'b0;
    logic          rst_n = 1'b1;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_en = 1'b0;
    logic          fifo_flush = 1'b0;
    logic          rg_fifo_ovw_en = 1'b0;
    logic [AW:0]   rg_fifo_waterline = '0;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic [AW:0]   fifo_cnt;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_upov_flag;
    logic          fifo_downov_flag;
    logic          fifo_waterline_flag;

    int checks = 0;
    int errors = 0;
    bit cmp_on = 1'b0;

    always #5 clk_32k = ~clk_32k;

    fifo_ctrl #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk_32k             (clk_32k),
        .rst_n               (rst_n),
        .wr_en               (wr_en),
        .wr_data             (wr_data),
        .rd_en               (rd_en),
        .rd_data             (rd_data),
        .rd_valid            (rd_valid),
        .fifo_flush          (fifo_flush),
        .rg_fifo_ovw_en      (rg_fifo_ovw_en),
        .rg_fifo_waterline   (rg_fifo_waterline),
        .fifo_cnt            (fifo_cnt),
        .fifo_full           (fifo_full),
        .fifo_empty          (fifo_empty),
        .fifo_upov_flag      (fifo_upov_flag),
        .fifo_downov_flag    (fifo_downov_flag),
        .fifo_waterline_flag (fifo_waterline_flag)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: contents as a queue, occupancy is its size.
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_rd_data = '0;
    bit m_rd_valid = 1'b0;
    bit m_upov = 1'b0;
    bit m_downov = 1'b0;
    bit m_wl = 1'b0;

    function automatic void model_reset();
        q.delete();
        m_rd_data  = '0;
        m_rd_valid = 1'b0;
        m_upov     = 1'b0;
        m_downov   = 1'b0;
        m_wl       = 1'b0;
    endfunction

    function automatic void model_step();
        int old_n;
        int wl;
        old_n = q.size();
        wl = int'(rg_fifo_waterline);
        m_rd_valid = 1'b0;
        m_upov     = 1'b0;
        m_downov   = 1'b0;
        m_wl       = 1'b0;
        if (fifo_flush) begin
            q.delete();
            return;
        end
        if (rd_en) begin
            if (old_n > 0) begin
                m_rd_data  = q.pop_front();
                m_rd_valid = 1'b1;
            end else begin
                m_downov = 1'b1;
            end
        end
        if (wr_en) begin
            if (q.size() < DEPTH) begin
                q.push_back(wr_data);
            end else begin
                m_upov = 1'b1;
                if (rg_fifo_ovw_en) begin
                    void'(q.pop_front());
                    q.push_back(wr_data);
                end
            end
        end
        m_wl = (wl != 0) && (old_n < wl) && (q.size() >= wl);
    endfunction

    always @(posedge clk_32k or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    // Every-cycle comparison of DUT against the model.
    always @(negedge clk_32k) begin
        if (cmp_on) begin
            chk("cmp_cnt",      32'(fifo_cnt),            32'(q.size()));
            chk("cmp_full",     32'(fifo_full),           32'(q.size() == DEPTH));
            chk("cmp_empty",    32'(fifo_empty),          32'(q.size() == 0));
            chk("cmp_rd_valid", 32'(rd_valid),            32'(m_rd_valid));
            chk("cmp_rd_data",  32'(rd_data),             32'(m_rd_data));
            chk("cmp_upov",     32'(fifo_upov_flag),      32'(m_upov));
            chk("cmp_downov",   32'(fifo_downov_flag),    32'(m_downov));
            chk("cmp_wl",       32'(fifo_waterline_flag), 32'(m_wl));
        end
    end

    task automatic cyc(input bit w, input logic [DW-1:0] d, input bit r, input bit f);
        @(negedge clk_32k);
        wr_en      = w;
        wr_data    = d;
        rd_en      = r;
        fifo_flush = f;
    endtask

    task automatic settle();
        @(posedge clk_32k);
        #1;
    endtask

    task automatic chk_flags_clear(input string name);
        chk(name, 32'({fifo_upov_flag, fifo_downov_flag, fifo_waterline_flag}), 32'(0));
    endtask

    initial begin
        #1 rst_n = 1'b0;
        cmp_on = 1'b1;
        #2;
        chk("rst_cnt", 32'(fifo_cnt), 32'(0));
        chk("rst_empty", 32'(fifo_empty), 32'(1));
        chk("rst_full", 32'(fifo_full), 32'(0));
        chk("rst_rd_valid", 32'(rd_valid), 32'(0));
        chk("rst_rd_data", 32'(rd_data), 32'(0));
        chk_flags_clear("rst_flags");
        @(negedge clk_32k);
        rst_n = 1'b1;

        // Basic push 5 / pop 5.
        for (int i = 1; i <= 5; i++) cyc(1'b1, DW'(i), 1'b0, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            cyc(1'b0, '0, 1'b1, 1'b0);
            settle();
            chk("t1_rd_data", 32'(rd_data), 32'(i));
            chk("t1_rd_valid", 32'(rd_valid), 32'(1));
        end
        cyc(1'b0, '0, 1'b0, 1'b0);
        settle();
        chk("t1_cnt", 32'(fifo_cnt), 32'(0));
        chk("t1_empty", 32'(fifo_empty), 32'(1));
        chk("t1_rd_valid_end", 32'(rd_valid), 32'(0));
        chk_flags_clear("t1_flags");

        // Waterline at 8.
        rg_fifo_waterline = 6'd8;
        for (int k = 1; k <= 10; k++) begin
            cyc(1'b1, DW'(16'h0040 + k), 1'b0, 1'b0);
            settle();
            chk("t2_wl_push", 32'(fifo_waterline_flag), 32'(k == 8));
        end
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, '0, 1'b1, 1'b0);
            settle();
            chk("t2_wl_pop", 32'(fifo_waterline_flag), 32'(0));
        end
        for (int k = 0; k < 2; k++) begin
            cyc(1'b1, DW'(16'h0080 + k), 1'b0, 1'b0);
            settle();
            chk("t2_wl_refill", 32'(fifo_waterline_flag), 32'(k == 1));
        end
        cyc(1'b0, '0, 1'b0, 1'b1);
        settle();
        rg_fifo_waterline = 6'd0;

        // Overflow with drop, then with overwrite.
        for (int m = 0; m < 2; m++) begin
            cyc(1'b0, '0, 1'b0, 1'b0);
            rg_fifo_ovw_en = (m == 1);
            for (int i = 0; i < DEPTH; i++) cyc(1'b1, DW'(16'h0100 + i), 1'b0, 1'b0);
            cyc(1'b1, 16'hAAAA, 1'b0, 1'b0);
            settle();
            chk("t3_upov", 32'(fifo_upov_flag), 32'(1));
            chk("t3_cnt_full", 32'(fifo_cnt), 32'(32));
            chk("t3_full", 32'(fifo_full), 32'(1));
            for (int i = 0; i < DEPTH; i++) begin
                cyc(1'b0, '0, 1'b1, 1'b0);
                settle();
                if (m == 0)
                    chk("t3_drop_pop", 32'(rd_data), 32'(16'h0100 + i));
                else if (i < DEPTH - 1)
                    chk("t3_ovw_pop", 32'(rd_data), 32'(16'h0101 + i));
                else
                    chk("t3_ovw_last", 32'(rd_data), 32'(16'hAAAA));
            end
        end
        cyc(1'b0, '0, 1'b0, 1'b0);
        rg_fifo_ovw_en = 1'b0;

        // Underflow.
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, '0, 1'b1, 1'b0);
            settle();
            chk("t4_downov", 32'(fifo_downov_flag), 32'(1));
            chk("t4_rd_valid", 32'(rd_valid), 32'(0));
        end
        cyc(1'b1, 16'h5555, 1'b1, 1'b0);
        settle();
        chk("t4_downov_push", 32'(fifo_downov_flag), 32'(1));
        chk("t4_cnt", 32'(fifo_cnt), 32'(1));
        cyc(1'b0, '0, 1'b1, 1'b0);
        settle();
        chk("t4_pop", 32'(rd_data), 32'(16'h5555));

        // Full with simultaneous push and pop.
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, DW'(16'h0200 + i), 1'b0, 1'b0);
        cyc(1'b1, 16'hBEEF, 1'b1, 1'b0);
        settle();
        chk("t5_upov", 32'(fifo_upov_flag), 32'(0));
        chk("t5_cnt", 32'(fifo_cnt), 32'(32));
        chk("t5_rd_data", 32'(rd_data), 32'(16'h0200));
        chk("t5_rd_valid", 32'(rd_valid), 32'(1));
        cyc(1'b0, '0, 1'b0, 1'b1);
        settle();

        // Flush with concurrent push/pop.
        for (int i = 0; i < 20; i++) cyc(1'b1, DW'(16'h0300 + i), 1'b0, 1'b0);
        cyc(1'b1, 16'hDEAD, 1'b1, 1'b1);
        settle();
        chk("t6_cnt", 32'(fifo_cnt), 32'(0));
        chk("t6_empty", 32'(fifo_empty), 32'(1));
        chk("t6_rd_valid", 32'(rd_valid), 32'(0));
        chk("t6_rd_data_hold", 32'(rd_data), 32'(16'h0200));
        chk_flags_clear("t6_flags");

        // Reset in the middle of a push burst.
        for (int i = 0; i < 6; i++) cyc(1'b1, DW'(16'h0400 + i), 1'b0, 1'b0);
        @(posedge clk_32k);
        #3 rst_n = 1'b0;
        #1;
        chk("t7_cnt", 32'(fifo_cnt), 32'(0));
        chk("t7_empty", 32'(fifo_empty), 32'(1));
        chk("t7_full", 32'(fifo_full), 32'(0));
        chk("t7_rd_data", 32'(rd_data), 32'(0));
        chk("t7_rd_valid", 32'(rd_valid), 32'(0));
        chk_flags_clear("t7_flags");
        @(negedge clk_32k);
        rst_n   = 1'b1;
        wr_en   = 1'b1;
        wr_data = 16'h1234;
        rd_en   = 1'b0;
        settle();
        chk("t7_first_push", 32'(fifo_cnt), 32'(1));
        cyc(1'b0, '0, 1'b1, 1'b0);
        settle();
        chk("t7_first_pop", 32'(rd_data), 32'(16'h1234));
        cyc(1'b0, '0, 1'b0, 1'b0);
        settle();
        @(negedge clk_32k);
        cmp_on = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_fifo_ctrl
